// File: rtl/imem_pkg.sv
// Shared types and sizing for the instruction-memory loader.
// The state enumeration includes CSUM even when the checksum build option is off.
package imem_pkg;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      DONE = 2'd1,
      ERR  = 2'd2,
      CSUM = 2'd3
   } state_e;

   localparam int FETCH_BYTES   = 10;
   localparam int WIN_W         = 8 * FETCH_BYTES;
   localparam int DEF_MEM_BYTES = 2048;

endpackage

// File: rtl/imem_loader_if.sv
// Loader byte stream plus fetch-window read port. The master drives the stream and the PC.
// The slave returns ready, the window and status; ready is the only backpressure.
interface imem_loader_if #(
   parameter int CNT_W = 12
);
   logic                    ld_valid;
   logic [7:0]              ld_data;
   logic                    ld_last;
   logic                    ld_ready;
   logic [63:0]             fetch_pc;
   logic [8*10-1:0]         fetch_bytes;
   logic                    imem_er;
   logic                    cpu_run;
   logic                    load_err;
   logic [CNT_W-1:0]        load_count;

   modport master (
      output ld_valid, ld_data, ld_last, fetch_pc,
      input  ld_ready, fetch_bytes, imem_er, cpu_run, load_err, load_count
   );

   modport slave (
      input  ld_valid, ld_data, ld_last, fetch_pc,
      output ld_ready, fetch_bytes, imem_er, cpu_run, load_err, load_count
   );
endinterface

// File: rtl/imem_window.sv
// Combinational 10-byte fetch window; bytes at or beyond load_count read as zero.
// Zero latency, no backpressure; address sums are done at 65 bits so a huge PC cannot wrap.
module imem_window
   import imem_pkg::*;
#(
   parameter int MEM_BYTES = DEF_MEM_BYTES,
   parameter int CNT_W     = 12
) (
   input  logic [7:0]       mem_i [MEM_BYTES],
   input  logic [CNT_W-1:0] load_count_i,
   input  logic [63:0]      fetch_pc_i,
   output logic [WIN_W-1:0] fetch_bytes_o,
   output logic             imem_er_o
);
   localparam int AW = $clog2(MEM_BYTES);

   logic [64:0] addr;

   always_comb begin
      fetch_bytes_o = '0;
      addr          = '0;
      for (int i = 0; i < FETCH_BYTES; i++) begin
         addr = {1'b0, fetch_pc_i} + 65'(i);
         // load_count never exceeds MEM_BYTES, so a passing compare implies a legal index
         if (addr < 65'(load_count_i)) begin
            fetch_bytes_o[8*i +: 8] = mem_i[addr[AW-1:0]];
         end
      end
   end

   assign imem_er_o = ({1'b0, fetch_pc_i} + 65'(FETCH_BYTES - 1)) >= 65'(MEM_BYTES);

endmodule

// File: rtl/imem_loader.sv
// Streams program bytes into instruction memory, then releases the CPU; one byte per cycle, write visible next cycle.
// ld_ready is low while in reset and in the terminal DONE/ERR states; IMEM_LOADER_CSUM_EN adds a trailing checksum byte.
module imem_loader
   import imem_pkg::*;
#(
   parameter int MEM_BYTES = DEF_MEM_BYTES,
   parameter int CNT_W     = 12
) (
   input  logic          clk,
   input  logic          reset,
   imem_loader_if.slave  bus
);
   localparam int AW = $clog2(MEM_BYTES);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] ptr_q, ptr_d;
   logic [7:0]       mem_q [MEM_BYTES];
   logic             accept;
   logic             wr_en;
`ifdef IMEM_LOADER_CSUM_EN
   logic [7:0]       csum_q, csum_d;
`endif

   always_comb begin
`ifdef IMEM_LOADER_CSUM_EN
      bus.ld_ready = !reset && ((state_q == LOAD) || (state_q == CSUM));
`else
      bus.ld_ready = !reset && (state_q == LOAD);
`endif
   end

   assign accept         = bus.ld_valid && bus.ld_ready;
   assign bus.cpu_run    = (state_q == DONE);
   assign bus.load_err   = (state_q == ERR);
   assign bus.load_count = ptr_q;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      wr_en   = 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_d  = csum_q;
`endif
      case (state_q)
         LOAD: begin
            if (accept) begin
               wr_en = 1'b1;
               ptr_d = ptr_q + CNT_W'(1);
`ifdef IMEM_LOADER_CSUM_EN
               csum_d = csum_q + bus.ld_data;
               if (bus.ld_last) begin
                  state_d = CSUM;
               end else if (ptr_q == CNT_W'(MEM_BYTES - 1)) begin
                  state_d = ERR;
               end
`else
               if (bus.ld_last) begin
                  state_d = DONE;
               end else if (ptr_q == CNT_W'(MEM_BYTES - 1)) begin
                  state_d = ERR;
               end
`endif
            end
         end
`ifdef IMEM_LOADER_CSUM_EN
         // The checksum byte is compared only; it is neither stored nor counted
         CSUM: begin
            if (accept) begin
               state_d = (bus.ld_data == csum_q) ? DONE : ERR;
            end
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= LOAD;
         ptr_q   <= '0;
`ifdef IMEM_LOADER_CSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
`ifdef IMEM_LOADER_CSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   // Storage is deliberately left out of reset; stale bytes are masked by load_count
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[ptr_q[AW-1:0]] <= bus.ld_data;
      end
   end

   imem_window #(
      .MEM_BYTES (MEM_BYTES),
      .CNT_W     (CNT_W)
   ) u_window (
      .mem_i         (mem_q),
      .load_count_i  (ptr_q),
      .fetch_pc_i    (bus.fetch_pc),
      .fetch_bytes_o (bus.fetch_bytes),
      .imem_er_o     (bus.imem_er)
   );

endmodule
